serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares the single byte-wide transmit port of the USB serial core (ready/strobe/data handshake) between N independent byte sources: a heartbeat generator, a loopback echo, debug printers. Each source gets a one-byte holding slot. A round-robin scheduler drains the slots into the sink. An optional line-lock keeps one source's text line contiguous, so console output from different sources never interleaves mid-line. The block sits between the byte producers and the TX FIFO or `usb_serial` TX port, in the 12 MHz `clk` domain.

## Interface
Parameters:
- `N`, 2: number of sources, 2..4.
- `LINE_LOCK`, 1: 1 enables the line-lock state machine; 0 makes arbitration byte-granular round-robin.
- `EOL`, 8'h0A: byte that ends a line and releases the lock.
- `TIMEOUT`, 4096: idle cycles after which a lock is forcibly released, 2..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `src_strobe` in N: source i presents a byte this cycle.
- `src_data` in 8*N: source i byte at [8i+7:8i].
- `src_ready` out N: slot i empty; registered.
- `sink_ready` in 1: downstream can accept a byte.
- `sink_strobe` out 1: one-cycle byte-valid pulse; registered.
- `sink_data` out 8: byte, valid while `sink_strobe`; registered.
- `grant` out $clog2(N): index of the source of the most recent issued byte.
- `locked` out 1: high in LOCKED state.

## Operation
- Slot i: when `src_strobe[i] && src_ready[i]`, the slot captures `src_data[i]` and sets full. `src_strobe[i]` while full is ignored and the byte is dropped. `src_ready[i] = !full[i]`.
- Issue condition: `sink_ready && !sink_strobe` && a slot is eligible.
  - In IDLE, the eligible slot is the first full slot scanning from `ptr+1` mod N.
  - In LOCKED, only the owner slot is eligible; all other slots wait even if full.
- On issue from slot i:
  - `sink_strobe<=1`, `sink_data<=slot[i]`.
  - full[i] clears.
  - `grant<=i`, `ptr<=i`.
  - The timeout counter clears.
- State machine, LINE_LOCK=1:
  - IDLE -> LOCKED, owner=i: issued byte != EOL.
  - LOCKED -> IDLE: owner issues EOL.
  - LOCKED -> IDLE: timeout counter reaches TIMEOUT-1.
  - The counter increments each LOCKED cycle in which no byte is issued.
  - Bytes from the owner that are not EOL keep LOCKED and clear the counter.
  - EOL issued in IDLE leaves the state IDLE.
- LINE_LOCK=0: state is constant IDLE and `locked`=0.
- Simultaneous events:
  - Capture and drain of the same slot cannot coincide, because `src_ready` was low during the drain cycle.
  - Capture in other slots proceeds during any issue.
  - Timeout expiry and issue in the same cycle: the issue wins and the transition follows the issued byte.
- Reset, asynchronous, at any time including mid-line:
  - All slots empty; `src_ready` all 1.
  - `sink_strobe`=0, `sink_data`=0, `grant`=0, `locked`=0.
  - State IDLE, counter 0, `ptr`=N-1 (so source 0 is first).
  - In-flight bytes are lost.

## Timing
- Capture to `sink_strobe`: 2 cycles minimum.
  - Cycle 0: strobe.
  - Cycle 1: full, issue decided.
  - Cycle 2: `sink_strobe` high.
- Throughput: at most one byte every 2 cycles, because the `!sink_strobe` gap is mandatory. This matches `usb_serial`'s strobe/ready-deassert latency.
- Slot refill: `src_ready[i]` rises the cycle after drain, so a source can supply at most one byte per 2 cycles.
- `sink_ready` is sampled only in the decision cycle. A drop of `sink_ready` after a strobe has no effect on that byte.
- `locked` and `grant` update in the same cycle as `sink_strobe`.

## Structure
- Package `serial_arb_pkg`:
  - State enum {IDLE, LOCKED}.
  - Default EOL constant 8'h0A.
  - Width helper for `grant`.
- Sub-module `byte_slot`: one-entry holding register with capture/drain and full flag, instantiated N times.
- Round-robin pick and the FSM live in `serial_tx_arbiter`.

## Test plan
- Single source, N=2, `sink_ready`=1: source 0 strobes 'A' at cycle 0 -> `sink_strobe` at cycle 2 with `sink_data`=8'h41, `grant`=0, `locked`=1, `src_ready[0]` high at cycle 3.
- Fairness, LINE_LOCK=0: both slots hold 'x'/'y' continuously refilled -> sink sequence alternates x,y,x,y with a strobe every 2 cycles.
- Line lock: source 0 sends "ab\n", source 1 sends "CD\n", all bytes offered at once -> sink order a,b,\n,C,D,\n; `locked` drops the cycle '\n' issues.
- Timeout, TIMEOUT=16: source 0 sends 'a' then stalls, source 1 holds 'Z' -> `locked` drops after 16 idle cycles and 'Z' issues 2 cycles later.
- Backpressure and drop: hold `sink_ready`=0 for 50 cycles with slot 0 full and source 0 strobing 'q' -> no `sink_strobe`, 'q' dropped, original byte issued after `sink_ready` rises.
- Reset mid-line: assert `reset_n`=0 while LOCKED with both slots full -> all outputs 0 and `src_ready`=2'b11 immediately; after release, the first issue comes from source 0.

Source files
------------

// File: rtl/serial_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arb_pkg
//  Description : Shared types and helpers for the serial TX arbiter. Holds the
//                arbiter state encoding, the default end-of-line byte and the
//                width helper used to size the grant index.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arb_pkg;

   // Arbiter state: IDLE arbitrates round-robin, LOCKED serves only the owner.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Default line terminator (ASCII line feed).
   localparam logic [7:0] C_EOL_DEFAULT = 8'h0A;

   // Bits needed to index n sources; never less than one bit.
   function automatic int unsigned grant_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_slot.sv
`default_nettype none
// ============================================================================
//  Module      : byte_slot
//  Description : One-entry byte holding register with a full flag. A capture
//                is accepted only while empty; a capture offered while full is
//                silently dropped. A drain empties the slot.
//  Ports       : clk, reset_n      - clock, asynchronous active-low reset
//                capture           - source offers capture_data this cycle
//                capture_data[7:0] - byte offered by the source
//                drain             - arbiter takes the held byte this cycle
//                full              - slot holds a byte
//                data[7:0]         - held byte
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_slot (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       capture,
   input  logic [7:0] capture_data,
   input  logic       drain,
   output logic       full,
   output logic [7:0] data
);

   logic       r_full;
   logic [7:0] r_data;

   // Capture needs an empty slot and drain is only issued on a full slot, so
   // the two can never act in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 1'b0;
         r_data <= 8'h00;
      end else if (capture && !r_full) begin
         r_full <= 1'b1;
         r_data <= capture_data;
      end else if (drain) begin
         r_full <= 1'b0;
      end
   end

   assign full = r_full;
   assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_arbiter
//  Description : Shares one byte-wide strobe/ready transmit port between N byte
//                sources. Each source owns a one-byte slot; a round-robin
//                scheduler drains the slots. With LINE_LOCK set, a source that
//                issues a non-EOL byte owns the sink until it issues EOL or the
//                lock idles out after TIMEOUT cycles.
//  Ports       : clk, reset_n          - clock, asynchronous active-low reset
//                src_strobe[N-1:0]     - source i presents a byte
//                src_data[8N-1:0]      - source i byte at [8i+7:8i]
//                src_ready[N-1:0]      - slot i empty
//                sink_ready            - downstream can accept a byte
//                sink_strobe           - one-cycle byte-valid pulse
//                sink_data[7:0]        - byte, valid with sink_strobe
//                grant                 - source index of the last issued byte
//                locked                - line lock held
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
   import serial_arb_pkg::*;
#(
   parameter int unsigned N         = 2,
   parameter int unsigned LINE_LOCK = 1,
   parameter logic [7:0]  EOL       = C_EOL_DEFAULT,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N-1:0]                src_strobe,
   input  logic [8*N-1:0]              src_data,
   output logic [N-1:0]                src_ready,
   input  logic                        sink_ready,
   output logic                        sink_strobe,
   output logic [7:0]                  sink_data,
   output logic [grant_width(N)-1:0]   grant,
   output logic                        locked
);

   localparam int unsigned GW             = grant_width(N);
   localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT - 1);

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   arb_state_t    r_state;
   logic [GW-1:0] r_owner;
   logic [15:0]   r_cnt;
   logic [GW-1:0] r_ptr;
   logic          r_sink_strobe;
   logic [7:0]    r_sink_data;
   logic [GW-1:0] r_grant;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic [N-1:0]  w_full;
   logic [N-1:0]  w_drain;
   logic [7:0]    w_slot_data [N];
   logic          w_found;
   logic [GW-1:0] w_pick;
   logic [7:0]    w_pick_data;
   logic          w_issue;
   int unsigned   w_idx;
   arb_state_t    w_state_nxt;
   logic [GW-1:0] w_owner_nxt;
   logic [15:0]   w_cnt_nxt;

   // ------------------------------------------------------------------------
   // Per-source holding slots
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < N; i++) begin : g_slot
         assign w_drain[i] = w_issue && (w_pick == GW'(i));

         byte_slot u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .capture      (src_strobe[i]),
            .capture_data (src_data[8*i +: 8]),
            .drain        (w_drain[i]),
            .full         (w_full[i]),
            .data         (w_slot_data[i])
         );
      end
   endgenerate

   assign src_ready = ~w_full;

   // ------------------------------------------------------------------------
   // Slot selection: owner only while locked, otherwise the first full slot
   // scanning upward from the one after the last served source.
   // ------------------------------------------------------------------------
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_owner;
      w_idx   = 0;
      if (r_state == LOCKED) begin
         w_found = w_full[r_owner];
      end else begin
         for (int unsigned k = 1; k <= N; k++) begin
            w_idx = (32'(r_ptr) + k) % N;
            if (!w_found && w_full[w_idx]) begin
               w_found = 1'b1;
               w_pick  = GW'(w_idx);
            end
         end
      end
   end

   assign w_pick_data = w_slot_data[w_pick];

   // The !sink_strobe term enforces the idle gap after every byte that the
   // downstream needs to drop its ready.
   assign w_issue = sink_ready && !r_sink_strobe && w_found;

   // ------------------------------------------------------------------------
   // Line-lock state machine: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      if (LINE_LOCK == 0) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 16'd0;
      end else if (w_issue) begin
         // An issue always wins over a coinciding timeout.
         w_cnt_nxt = 16'd0;
         if (w_pick_data == EOL) begin
            w_state_nxt = IDLE;
         end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_pick;
         end
      end else if (r_state == LOCKED) begin
         if (r_cnt == C_TIMEOUT_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 16'd0;
         end else begin
            w_cnt_nxt = r_cnt + 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Line-lock state machine: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_cnt   <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Sink port and round-robin pointer. The pointer resets to N-1 so that the
   // first scan starts at source 0.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sink_strobe <= 1'b0;
         r_sink_data   <= 8'h00;
         r_grant       <= '0;
         r_ptr         <= GW'(N - 1);
      end else begin
         r_sink_strobe <= w_issue;
         if (w_issue) begin
            r_sink_data <= w_pick_data;
            r_grant     <= w_pick;
            r_ptr       <= w_pick;
         end
      end
   end

   assign sink_strobe = r_sink_strobe;
   assign sink_data   = r_sink_data;
   assign grant       = r_grant;
   assign locked      = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_arbiter
//  Description : Directed self-checking bench for serial_tx_arbiter. One
//                instance with line lock (TIMEOUT=16), one byte-granular
//                round-robin instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;

   // line-lock instance
   logic [1:0]  src_strobe;
   logic [15:0] src_data;
   logic [1:0]  src_ready;
   logic        sink_ready;
   logic        sink_strobe;
   logic [7:0]  sink_data;
   logic [0:0]  grant;
   logic        locked;

   // round-robin instance
   logic [1:0]  rr_src_strobe;
   logic [15:0] rr_src_data;
   logic [1:0]  rr_src_ready;
   logic        rr_sink_ready;
   logic        rr_sink_strobe;
   logic [7:0]  rr_sink_data;
   logic [0:0]  rr_grant;
   logic        rr_locked;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;

   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];
   bit          feed_en  = 1'b0;

   logic [7:0]  rx_data   [$];
   logic        rx_locked [$];
   logic [7:0]  rr_rx     [$];
   int unsigned rr_t      [$];
   logic        rr_lk     [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_tx_arbiter #(
      .N(2), .LINE_LOCK(1), .EOL(8'h0A), .TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_strobe  (src_strobe),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .sink_ready  (sink_ready),
      .sink_strobe (sink_strobe),
      .sink_data   (sink_data),
      .grant       (grant),
      .locked      (locked)
   );

   serial_tx_arbiter #(
      .N(2), .LINE_LOCK(0), .EOL(8'h0A), .TIMEOUT(16)
   ) dut_rr (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_strobe  (rr_src_strobe),
      .src_data    (rr_src_data),
      .src_ready   (rr_src_ready),
      .sink_ready  (rr_sink_ready),
      .sink_strobe (rr_sink_strobe),
      .sink_data   (rr_sink_data),
      .grant       (rr_grant),
      .locked      (rr_locked)
   );

   // sink monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (sink_strobe) begin
         rx_data.push_back(sink_data);
         rx_locked.push_back(locked);
      end
      if (rr_sink_strobe) begin
         rr_rx.push_back(rr_sink_data);
         rr_t.push_back(cyc);
         rr_lk.push_back(rr_locked);
      end
   end

   // source feeders: offer the next queued byte whenever the slot is empty
   always @(posedge clk) begin
      #1;
      if (feed_en) begin
         if (q0.size() > 0 && src_ready[0]) begin
            src_strobe[0]  = 1'b1;
            src_data[7:0]  = q0.pop_front();
         end else begin
            src_strobe[0]  = 1'b0;
         end
         if (q1.size() > 0 && src_ready[1]) begin
            src_strobe[1]  = 1'b1;
            src_data[15:8] = q1.pop_front();
         end else begin
            src_strobe[1]  = 1'b0;
         end
      end
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      feed_en       = 1'b0;
      q0.delete();
      q1.delete();
      reset_n       = 1'b0;
      src_strobe    = 2'b00;
      src_data      = 16'h0000;
      sink_ready    = 1'b1;
      rr_src_strobe = 2'b00;
      rr_src_data   = 16'h0000;
      rr_sink_ready = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      rx_data.delete();
      rx_locked.delete();
      rr_rx.delete();
      rr_t.delete();
      rr_lk.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nstb;
      int a_at, first_unlock, z_at;
      logic [7:0] exp_line [6];
      logic       exp_lock [6];

      // ---------------- reset state + single source latency ---------------
      apply_reset();
      chk_val("rst_src_ready",   32'(src_ready),   32'h3);
      chk_val("rst_sink_strobe", 32'(sink_strobe), 32'h0);
      chk_val("rst_sink_data",   32'(sink_data),   32'h0);
      chk_val("rst_grant",       32'(grant),       32'h0);
      chk_val("rst_locked",      32'(locked),      32'h0);

      src_strobe = 2'b01;
      src_data   = 16'h0041;
      tick();                                   // cycle 1
      src_strobe = 2'b00;
      chk_val("single_c1_ready0", 32'(src_ready[0]), 32'h0);
      chk_val("single_c1_strobe", 32'(sink_strobe),  32'h0);
      tick();                                   // cycle 2
      chk_val("single_c2_strobe", 32'(sink_strobe), 32'h1);
      chk_val("single_c2_data",   32'(sink_data),   32'h41);
      chk_val("single_c2_grant",  32'(grant),       32'h0);
      chk_val("single_c2_locked", 32'(locked),      32'h1);
      tick();                                   // cycle 3
      chk_val("single_c3_ready",  32'(src_ready),   32'h3);
      chk_val("single_c3_strobe", 32'(sink_strobe), 32'h0);

      // ---------------- fairness, byte-granular round-robin ---------------
      apply_reset();
      rr_src_strobe = 2'b11;
      rr_src_data   = {8'h79, 8'h78};           // 'y' on 1, 'x' on 0
      tick(20);
      rr_src_strobe = 2'b00;
      chk_val("rr_count_ge8", 32'(rr_rx.size() >= 8), 32'h1);
      for (int k = 0; k < 8 && k < rr_rx.size(); k++)
         chk_val($sformatf("rr_byte%0d", k), 32'(rr_rx[k]), (k % 2 == 0) ? 32'h78 : 32'h79);
      for (int k = 0; k < 7 && k + 1 < rr_t.size(); k++)
         chk_val($sformatf("rr_gap%0d", k), rr_t[k+1] - rr_t[k], 32'd2);
      if (rr_lk.size() > 0)
         chk_val("rr_never_locked", 32'(rr_lk[0]), 32'h0);

      // ---------------- line lock ----------------
      apply_reset();
      q0 = {8'h61, 8'h62, 8'h0A};               // "ab\n"
      q1 = {8'h43, 8'h44, 8'h0A};               // "CD\n"
      exp_line = '{8'h61, 8'h62, 8'h0A, 8'h43, 8'h44, 8'h0A};
      exp_lock = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      feed_en = 1'b1;
      tick(24);
      feed_en    = 1'b0;
      src_strobe = 2'b00;
      chk_val("line_count", 32'(rx_data.size()), 32'd6);
      for (int k = 0; k < 6 && k < rx_data.size(); k++) begin
         chk_val($sformatf("line_byte%0d", k),   32'(rx_data[k]),   32'(exp_line[k]));
         chk_val($sformatf("line_locked%0d", k), 32'(rx_locked[k]), 32'(exp_lock[k]));
      end

      // ---------------- lock timeout ----------------
      apply_reset();
      src_strobe = 2'b11;
      src_data   = {8'h5A, 8'h61};              // 'Z' on 1, 'a' on 0
      tick();                                   // cycle 1
      src_strobe = 2'b00;
      a_at = -1; first_unlock = -1; z_at = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (sink_strobe && sink_data == 8'h61 && a_at < 0) a_at = k;
         if (a_at >= 0 && !locked && first_unlock < 0) first_unlock = k;
         if (sink_strobe && sink_data == 8'h5A && z_at < 0) begin
            z_at = k;
            chk_val("tmo_z_grant", 32'(grant), 32'h1);
         end
      end
      chk_val("tmo_a_at",       32'(a_at),                    32'd0);
      chk_val("tmo_lock_hold",  32'(first_unlock - a_at),     32'd16);
      chk_val("tmo_z_after",    32'(z_at - (first_unlock - 1)), 32'd2);

      // ---------------- backpressure and drop ----------------
      apply_reset();
      sink_ready = 1'b0;
      src_strobe = 2'b01;
      src_data   = 16'h006D;                    // 'm'
      tick();
      src_data   = 16'h0071;                    // 'q' while full: dropped
      nstb = 0;
      repeat (50) begin
         tick();
         if (sink_strobe) nstb++;
      end
      chk_val("bp_no_strobe", 32'(nstb),         32'd0);
      chk_val("bp_ready0",    32'(src_ready[0]), 32'h0);
      src_strobe = 2'b00;
      sink_ready = 1'b1;
      tick();
      chk_val("bp_strobe", 32'(sink_strobe), 32'h1);
      chk_val("bp_data",   32'(sink_data),   32'h6D);
      nstb = 0;
      repeat (10) begin
         tick();
         if (sink_strobe) nstb++;
      end
      chk_val("bp_q_dropped", 32'(nstb),      32'd0);
      chk_val("bp_ready_end", 32'(src_ready), 32'h3);

      // ---------------- reset mid-line ----------------
      apply_reset();
      src_strobe = 2'b11;
      src_data   = {8'h4B, 8'h68};              // 'K' on 1, 'h' on 0
      tick();
      src_strobe = 2'b00;
      tick();
      chk_val("ml_first_data", 32'(sink_data), 32'h68);
      src_strobe = 2'b01;
      src_data   = {8'h4B, 8'h69};              // 'i'
      tick();
      src_strobe = 2'b00;
      chk_val("ml_locked",     32'(locked),    32'h1);
      chk_val("ml_both_full",  32'(src_ready), 32'h0);
      reset_n = 1'b0;
      #1;
      chk_val("ml_rst_ready",  32'(src_ready),   32'h3);
      chk_val("ml_rst_strobe", 32'(sink_strobe), 32'h0);
      chk_val("ml_rst_data",   32'(sink_data),   32'h0);
      chk_val("ml_rst_grant",  32'(grant),       32'h0);
      chk_val("ml_rst_locked", 32'(locked),      32'h0);
      tick(2);
      reset_n = 1'b1;
      tick();
      src_strobe = 2'b11;
      src_data   = {8'h76, 8'h75};              // 'v' on 1, 'u' on 0
      tick();
      src_strobe = 2'b00;
      tick();
      chk_val("ml_after_strobe", 32'(sink_strobe), 32'h1);
      chk_val("ml_after_data",   32'(sink_data),   32'h75);
      chk_val("ml_after_grant",  32'(grant),       32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
